// File: rtl/ad_sequencer_if.sv
// ad_sequencer_if
// Bundles the serial ADC pins, the published result and the UART
// start/busy handshake of the conversion sequencer.
//   master : the sequencer (drives ad_sclk/ad_cs_n, sample, tx_*, overrun)
//   slave  : the ADC + UART side (drives ad_dout, tx_busy)
interface ad_sequencer_if;
    logic       ad_sclk;
    logic       ad_cs_n;
    logic       ad_dout;
    logic [7:0] sample;
    logic       sample_valid;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       overrun;

    modport master (
        output ad_sclk, ad_cs_n, sample, sample_valid, tx_data, tx_start, overrun,
        input  ad_dout, tx_busy
    );

    modport slave (
        input  ad_sclk, ad_cs_n, sample, sample_valid, tx_data, tx_start, overrun,
        output ad_dout, tx_busy
    );
endinterface

// File: rtl/ad_sequencer.sv
// ad_sequencer
// Launches periodic conversions on the 8-bit serial ADC, shifts in the
// result byte MSB first, optionally averages 2^AVG_LOG2 results, and
// publishes each result to the display path (sample/sample_valid) and to
// the UART transmitter through a start/busy handshake.
//
// Ports:
//   clk    : system clock
//   rstn   : asynchronous active-low reset
//   enable : conversions run while high; low aborts and clears run state
//   bus    : ad_sequencer_if.master (ADC pins, sample, tx handshake, overrun)
//
// Optional feature: define AD_SEQ_AVG_EN to average 2^AVG_LOG2 conversions
// per published result; undefined, every conversion is published directly.
module ad_sequencer #(
    parameter int CLK_DIV       = 4096,
    parameter int SAMPLE_PERIOD = 131072,
    parameter int CS_SETUP      = 64,
    parameter int AVG_LOG2      = 2
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           enable,
    ad_sequencer_if.master bus
);

    localparam int PER_W   = $clog2(SAMPLE_PERIOD);
    localparam int CNT_MAX = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [PER_W-1:0] PER_LAST   = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

    state_t           state;
    logic [PER_W-1:0] period_cnt;
    logic [CNT_W-1:0] phase_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             publish_req;
    logic [7:0]       publish_byte;
    logic             pending;

    logic             cs_n_q;
    logic             sclk_q;
    logic [7:0]       sample_q;
    logic             valid_q;
    logic [7:0]       tx_data_q;
    logic             tx_start_q;
    logic             overrun_q;

`ifdef AD_SEQ_AVG_EN
    localparam int ACC_W = 8 + AVG_LOG2;
    localparam logic [AVG_LOG2:0] AVG_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0]  acc;
    logic [AVG_LOG2:0] avg_cnt;
    logic [ACC_W-1:0]  acc_sum;

    assign acc_sum = acc + ACC_W'(shift_reg);
`else
    // AVG_LOG2 has no role without averaging; this sink keeps the parameter
    // list identical across both builds.
    logic unused_avg_log2;
    assign unused_avg_log2 = ^AVG_LOG2;
`endif

    // Whole sequencer in one registered process. Order of work per edge:
    // period counter, publish/tx stage (fed by DONE one cycle earlier),
    // conversion FSM, and overrun detection on a busy launch slot.
    // enable low overrides everything except the held sample value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            period_cnt   <= '0;
            phase_cnt    <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            publish_req  <= 1'b0;
            publish_byte <= '0;
            pending      <= 1'b0;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b0;
            sample_q     <= '0;
            valid_q      <= 1'b0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef AD_SEQ_AVG_EN
            acc          <= '0;
            avg_cnt      <= '0;
`endif
        end else if (!enable) begin
            state       <= IDLE;
            period_cnt  <= '0;
            phase_cnt   <= '0;
            bit_cnt     <= '0;
            publish_req <= 1'b0;
            pending     <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            valid_q     <= 1'b0;
            tx_start_q  <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef AD_SEQ_AVG_EN
            acc         <= '0;
            avg_cnt     <= '0;
`endif
        end else begin
            valid_q     <= 1'b0;
            tx_start_q  <= 1'b0;
            publish_req <= 1'b0;

            period_cnt <= (period_cnt == PER_LAST) ? '0 : period_cnt + PER_W'(1);

            // A fresh publish always wins over a pending send so only the
            // newest byte reaches the UART.
            if (publish_req) begin
                sample_q  <= publish_byte;
                valid_q   <= 1'b1;
                tx_data_q <= publish_byte;
                pending   <= 1'b1;
            end else if (pending && !bus.tx_busy) begin
                tx_start_q <= 1'b1;
                pending    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (period_cnt == '0) begin
                        state     <= SETUP;
                        cs_n_q    <= 1'b0;
                        phase_cnt <= '0;
                    end
                end
                SETUP: begin
                    if (phase_cnt == SETUP_LAST) begin
                        state     <= SHIFT;
                        phase_cnt <= '0;
                        bit_cnt   <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    if (phase_cnt == HALF_LAST) begin
                        phase_cnt <= '0;
                        if (!sclk_q) begin
                            sclk_q    <= 1'b1;
                            shift_reg <= {shift_reg[6:0], bus.ad_dout};
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                state  <= DONE;
                                cs_n_q <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
`ifdef AD_SEQ_AVG_EN
                    if (avg_cnt == AVG_LAST) begin
                        publish_byte <= 8'(acc_sum >> AVG_LOG2);
                        publish_req  <= 1'b1;
                        acc          <= '0;
                        avg_cnt      <= '0;
                    end else begin
                        acc     <= acc_sum;
                        avg_cnt <= avg_cnt + (AVG_LOG2 + 1)'(1);
                    end
`else
                    publish_byte <= shift_reg;
                    publish_req  <= 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase

            if (period_cnt == '0 && state != IDLE) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.ad_cs_n      = cs_n_q;
    assign bus.ad_sclk      = sclk_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.tx_start     = tx_start_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_ad_sequencer.sv
// tb_ad_sequencer
// Directed bench for ad_sequencer with CLK_DIV=2, CS_SETUP=2. The main
// instance uses SAMPLE_PERIOD=64; a second instance uses SAMPLE_PERIOD=20
// so its launch slots arrive while a conversion is still running.
// Cycle index k counts falling clock edges after enable is raised; the
// rising edge that sees enable first is E0 and its effect shows at k=1.
module tb_ad_sequencer;

    logic clk;
    logic rstn;
    logic enable;
    logic ovr_enable;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_sample = 8'h00;

    ad_sequencer_if seq_if ();
    ad_sequencer_if ovr_if ();

    ad_sequencer #(.CLK_DIV(2), .SAMPLE_PERIOD(64), .CS_SETUP(2), .AVG_LOG2(2)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .enable (enable),
        .bus    (seq_if)
    );

    ad_sequencer #(.CLK_DIV(2), .SAMPLE_PERIOD(20), .CS_SETUP(2), .AVG_LOG2(2)) dut_ovr (
        .clk    (clk),
        .rstn   (rstn),
        .enable (ovr_enable),
        .bus    (ovr_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial ADC model: loads the next byte from adc_list when CS_n falls,
    // presents the MSB, and moves to the next bit after each SCLK fall.
    logic [7:0] adc_list [4];
    logic [7:0] cur_byte  = 8'h00;
    int         bit_idx   = 7;
    int         conv_n    = 0;
    logic       prev_cs   = 1'b1;
    logic       prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (!enable) conv_n = 0;
        if (prev_cs && !seq_if.ad_cs_n) begin
            cur_byte = adc_list[conv_n % 4];
            conv_n++;
            bit_idx = 7;
        end else if (!seq_if.ad_cs_n && prev_sclk && !seq_if.ad_sclk && bit_idx > 0) begin
            bit_idx--;
        end
        seq_if.ad_dout = cur_byte[bit_idx];
        prev_cs   = seq_if.ad_cs_n;
        prev_sclk = seq_if.ad_sclk;
    end

    task automatic set_adc(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
        adc_list[0] = b0;
        adc_list[1] = b1;
        adc_list[2] = b2;
        adc_list[3] = b3;
    endtask

    task automatic idle_cycles(input int n);
        enable = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        repeat (2) @(negedge clk);
        if (seq_if.ad_cs_n !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_cs_n: got %b expected 1", seq_if.ad_cs_n);
        end
        checks++;
        if (seq_if.ad_sclk !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_sclk: got %b expected 0", seq_if.ad_sclk);
        end
        checks++;
        if ({seq_if.sample, seq_if.sample_valid, seq_if.tx_data, seq_if.tx_start, seq_if.overrun} !== 19'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got sample=%h valid=%b tx_data=%h tx_start=%b overrun=%b expected all 0",
                     seq_if.sample, seq_if.sample_valid, seq_if.tx_data, seq_if.tx_start, seq_if.overrun);
        end
        checks++;
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        if (seq_if.ad_cs_n !== 1'b1 || seq_if.sample_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL disabled_idle: got cs_n=%b valid=%b expected 1/0",
                     seq_if.ad_cs_n, seq_if.sample_valid);
        end
        checks++;
    endtask

    task automatic test_single();
        int cs_low = 0, rises = 0, rise_k = 0;
        int valid_n = 0, valid_k = 0, start_n = 0, start_k = 0;
        logic [7:0] valid_val = 8'h00, start_val = 8'h00;
        logic last_sclk = 1'b0, last_cs = 1'b1;
        set_adc(8'hA5, 8'hA5, 8'hA5, 8'hA5);
        @(negedge clk);
        enable = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (!seq_if.ad_cs_n) cs_low++;
            if (seq_if.ad_sclk && !last_sclk) rises++;
            if (seq_if.ad_cs_n && !last_cs && rise_k == 0) rise_k = k;
            if (seq_if.sample_valid) begin valid_n++; valid_k = k; valid_val = seq_if.sample; end
            if (seq_if.tx_start) begin start_n++; start_k = k; start_val = seq_if.tx_data; end
            last_sclk = seq_if.ad_sclk;
            last_cs   = seq_if.ad_cs_n;
        end
        idle_cycles(3);
        if (cs_low !== 34) begin failures++; $display("[TB] FAIL cs_low_cycles: got %0d expected 34", cs_low); end
        checks++;
        if (rises !== 8) begin failures++; $display("[TB] FAIL sclk_rises: got %0d expected 8", rises); end
        checks++;
        if (rise_k !== 35) begin failures++; $display("[TB] FAIL cs_rise_cycle: got %0d expected 35", rise_k); end
        checks++;
        if (valid_n !== 1 || valid_k !== 37) begin
            failures++;
            $display("[TB] FAIL single_valid: got count=%0d cycle=%0d expected 1 at 37", valid_n, valid_k);
        end
        checks++;
        if (valid_val !== 8'hA5) begin failures++; $display("[TB] FAIL single_sample: got %h expected a5", valid_val); end
        checks++;
        if (start_n !== 1 || start_k !== 38 || start_val !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL single_tx: got count=%0d cycle=%0d data=%h expected 1 at 38 data a5",
                     start_n, start_k, start_val);
        end
        checks++;
        exp_sample = 8'hA5;
    endtask

    task automatic test_averaging();
        int valid_n = 0, valid_k = 0, start_n = 0;
        logic [7:0] valid_val = 8'h00, start_val = 8'h00;
        set_adc(8'h10, 8'h20, 8'h30, 8'h41);
        @(negedge clk);
        enable = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (seq_if.sample_valid) begin valid_n++; valid_k = k; valid_val = seq_if.sample; end
            if (seq_if.tx_start) begin start_n++; start_val = seq_if.tx_data; end
        end
        idle_cycles(3);
        if (valid_n !== 1 || valid_k !== 229) begin
            failures++;
            $display("[TB] FAIL avg_valid: got count=%0d cycle=%0d expected 1 at 229", valid_n, valid_k);
        end
        checks++;
        if (valid_val !== 8'h28) begin failures++; $display("[TB] FAIL avg_sample: got %h expected 28", valid_val); end
        checks++;
        if (start_n !== 1 || start_val !== 8'h28) begin
            failures++;
            $display("[TB] FAIL avg_tx: got count=%0d data=%h expected 1 data 28", start_n, start_val);
        end
        checks++;
        exp_sample = 8'h28;
    endtask

    task automatic test_backpressure();
        int valid_k = 0, start_n = 0, start_k = 0, early = 0;
        logic [7:0] valid_val = 8'h00, start_val = 8'h00;
        set_adc(8'h3C, 8'h3C, 8'h3C, 8'h3C);
        @(negedge clk);
        enable = 1'b1;
        seq_if.tx_busy = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (seq_if.sample_valid) begin valid_k = k; valid_val = seq_if.sample; end
            if (seq_if.tx_start) begin
                start_n++; start_k = k; start_val = seq_if.tx_data;
                if (k <= 40) early++;
            end
            if (k == 40) seq_if.tx_busy = 1'b0;
        end
        idle_cycles(3);
        if (valid_k !== 37 || valid_val !== 8'h3C) begin
            failures++;
            $display("[TB] FAIL bp_valid: got cycle=%0d sample=%h expected 37 / 3c", valid_k, valid_val);
        end
        checks++;
        if (early !== 0) begin failures++; $display("[TB] FAIL bp_start_while_busy: got %0d expected 0", early); end
        checks++;
        if (start_n !== 1 || start_k !== 41) begin
            failures++;
            $display("[TB] FAIL bp_start: got count=%0d cycle=%0d expected 1 at 41", start_n, start_k);
        end
        checks++;
        if (start_val !== 8'h3C) begin failures++; $display("[TB] FAIL bp_tx_data: got %h expected 3c", start_val); end
        checks++;
        exp_sample = 8'h3C;
    endtask

    task automatic test_abort();
        int valid_n = 0, cs_low = 0, start_n = 0;
        set_adc(8'h5A, 8'h5A, 8'h5A, 8'h5A);
        @(negedge clk);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        if (seq_if.ad_cs_n !== 1'b0 || seq_if.ad_sclk !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_in_shift: got cs_n=%b sclk=%b expected 0/1", seq_if.ad_cs_n, seq_if.ad_sclk);
        end
        checks++;
        enable = 1'b0;
        @(negedge clk);
        if (seq_if.ad_cs_n !== 1'b1 || seq_if.ad_sclk !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_pins: got cs_n=%b sclk=%b expected 1/0", seq_if.ad_cs_n, seq_if.ad_sclk);
        end
        checks++;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (seq_if.sample_valid) valid_n++;
            if (!seq_if.ad_cs_n) cs_low++;
            if (seq_if.tx_start) start_n++;
        end
        if (valid_n !== 0 || start_n !== 0 || cs_low !== 0) begin
            failures++;
            $display("[TB] FAIL abort_quiet: got valid=%0d tx_start=%0d cs_low=%0d expected 0/0/0",
                     valid_n, start_n, cs_low);
        end
        checks++;
        if (seq_if.sample !== exp_sample) begin
            failures++;
            $display("[TB] FAIL abort_sample_hold: got %h expected %h", seq_if.sample, exp_sample);
        end
        checks++;
    endtask

    task automatic test_overrun();
        int drops = 0;
        @(negedge clk);
        ovr_enable = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 20 && ovr_if.overrun !== 1'b0) begin
                failures++;
                $display("[TB] FAIL overrun_early: got %b expected 0", ovr_if.overrun);
            end
            if (k == 20) checks++;
            if (k == 21 && ovr_if.overrun !== 1'b1) begin
                failures++;
                $display("[TB] FAIL overrun_set: got %b expected 1", ovr_if.overrun);
            end
            if (k == 21) checks++;
            if (k > 21 && ovr_if.overrun !== 1'b1) drops++;
        end
        if (drops !== 0) begin failures++; $display("[TB] FAIL overrun_sticky: got %0d drops expected 0", drops); end
        checks++;
        ovr_enable = 1'b0;
        @(negedge clk);
        if (ovr_if.overrun !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overrun_clear: got %b expected 0", ovr_if.overrun);
        end
        checks++;
    endtask

    task automatic test_async_reset();
        set_adc(8'h77, 8'h77, 8'h77, 8'h77);
        @(negedge clk);
        enable = 1'b1;
        repeat (13) @(negedge clk);
        if (seq_if.ad_cs_n !== 1'b0 || seq_if.ad_sclk !== 1'b1) begin
            failures++;
            $display("[TB] FAIL arst_pre: got cs_n=%b sclk=%b expected 0/1", seq_if.ad_cs_n, seq_if.ad_sclk);
        end
        checks++;
        #1 rstn = 1'b0;
        #1;
        if (seq_if.ad_cs_n !== 1'b1 || seq_if.ad_sclk !== 1'b0) begin
            failures++;
            $display("[TB] FAIL arst_pins: got cs_n=%b sclk=%b expected 1/0", seq_if.ad_cs_n, seq_if.ad_sclk);
        end
        checks++;
        if ({seq_if.sample, seq_if.sample_valid, seq_if.tx_data, seq_if.tx_start, seq_if.overrun} !== 19'h0) begin
            failures++;
            $display("[TB] FAIL arst_outputs: got sample=%h valid=%b tx_data=%h tx_start=%b overrun=%b expected all 0",
                     seq_if.sample, seq_if.sample_valid, seq_if.tx_data, seq_if.tx_start, seq_if.overrun);
        end
        checks++;
        enable = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        exp_sample = 8'h00;
    endtask

    initial begin
        enable         = 1'b0;
        ovr_enable     = 1'b0;
        seq_if.tx_busy = 1'b0;
        ovr_if.tx_busy = 1'b0;
        ovr_if.ad_dout = 1'b0;
        set_adc(8'h00, 8'h00, 8'h00, 8'h00);
        $display("[TB] starting ad_sequencer bench");
        test_reset();
`ifdef AD_SEQ_AVG_EN
        test_averaging();
`else
        test_single();
        test_backpressure();
`endif
        test_abort();
        test_overrun();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ad_sequencer.md
# ad_sequencer

Conversion sequencer and result scheduler for the 8-bit serial ADC on the `ad` bus. It launches periodic conversions by driving ADC chip-select and serial clock, and shifts in the result byte. It optionally averages several samples, then publishes each result to the display path and to the UART transmitter through a start/busy handshake. It replaces the free-running counter taps currently used to clock the ADC and to trigger UART sends.

## Interface
Parameters:
- `CLK_DIV`, default 4096: `clk` cycles per ADC SCLK half-period; must be ≥1.
- `SAMPLE_PERIOD`, default 131072: `clk` cycles between conversion launches; must exceed `CS_SETUP + 16*CLK_DIV + 2`.
- `CS_SETUP`, default 64: cycles from CS_n falling to the first SCLK rising edge; must be ≥1.
- `AVG_LOG2`, default 2: log2 of the number of samples averaged; only used with `AD_SEQ_AVG_EN`.

Ports:
- `clk` in 1: system clock.
- `rstn` in 1: asynchronous, active-low reset.
- `enable` in 1: run conversions while high.
- `ad_sclk` out 1: ADC serial clock.
- `ad_cs_n` out 1: ADC chip-select, active-low.
- `ad_dout` in 1: ADC serial data, MSB first.
- `sample` out 8: latest published result.
- `sample_valid` out 1: one-cycle pulse when `sample` updates.
- `tx_data` out 8: byte offered to the UART.
- `tx_start` out 1: one-cycle send request.
- `tx_busy` in 1: UART busy.
- `overrun` out 1: sticky flag, set when a launch slot is missed.

## Operation
- **Reset values:** `ad_cs_n`=1, `ad_sclk`=0, `sample`=0, `sample_valid`=0, `tx_data`=0, `tx_start`=0, `overrun`=0. State is IDLE, and the period counter, bit counter, accumulator and sample count are all 0.
- **Period counter:** counts 0..`SAMPLE_PERIOD`-1 and wraps while `enable`=1.
- **Launch:** occurs when the period counter is 0 and the state is IDLE. If the counter is 0 and the state is not IDLE, set `overrun` and skip the slot.
- **States:**
  - IDLE: `ad_cs_n`=1, `ad_sclk`=0.
  - SETUP: `ad_cs_n`=0; wait `CS_SETUP` cycles.
  - SHIFT: 8 SCLK periods. Each period is low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles. Sample `ad_dout` into the shift register (MSB first) on the cycle `ad_sclk` goes high.
  - DONE: one cycle; `ad_cs_n`=1 and the byte is taken. Return to IDLE.
- **Publish:** the byte is published in the cycle after DONE. `sample` updates and `sample_valid` pulses.
- **tx handshake:**
  - A publish sets a pending flag and loads `tx_data`.
  - While pending and `tx_busy`=0, pulse `tx_start` for one cycle and clear pending.
  - If a new publish arrives while pending, `tx_data` is overwritten and only the latest value is sent.
  - `tx_start` is never asserted while `tx_busy`=1.
- **`enable`=0:** takes effect on the next edge from any state. Go to IDLE with `ad_cs_n`=1 and `ad_sclk`=0. Clear the period counter, accumulator, sample count and pending flag. Clear `overrun`. No `sample_valid` is issued for the aborted conversion. `sample` holds its value.
- **Asynchronous reset mid-conversion:** outputs return to their reset values immediately, without waiting for a clock edge.

## Timing
- The first launch occurs on the first edge at which `enable`=1. `ad_cs_n` falls on that edge.
- `ad_cs_n` stays low for exactly `CS_SETUP + 16*CLK_DIV` cycles.
- `sample_valid` pulses 2 cycles after `ad_cs_n` rises: one cycle for DONE, one cycle to publish.
- `tx_start` occurs in the cycle after `sample_valid` if `tx_busy`=0. Otherwise it occurs in the first cycle after `tx_busy` is sampled low.
- Conversion launches are spaced exactly `SAMPLE_PERIOD` cycles apart.

## Configuration
- **`AD_SEQ_AVG_EN` defined:**
  - Each byte from DONE is added into an accumulator of width 8+`AVG_LOG2`, and the sample count is incremented.
  - When the count reaches 2^`AVG_LOG2`, publish `acc >> AVG_LOG2` (truncated, no rounding), then clear the accumulator and count.
  - `sample_valid` fires once per 2^`AVG_LOG2` conversions.
- **`AD_SEQ_AVG_EN` undefined:** every DONE byte is published directly. There is no accumulator, and `AVG_LOG2` is ignored.

## Test plan
All scenarios use `CLK_DIV`=2, `SAMPLE_PERIOD`=64, `CS_SETUP`=2, and a serial ADC model.
- **Single conversion, no averaging:** macro undefined, ADC model returns 0xA5, `enable` raised. Required: `ad_cs_n` low for 34 cycles; 8 SCLK rising edges; `sample`=0xA5 with `sample_valid` pulsing 2 cycles after `ad_cs_n` rises; `tx_start` with `tx_data`=0xA5 on the next cycle.
- **Averaging:** `AD_SEQ_AVG_EN` defined, `AVG_LOG2`=2, ADC returns 0x10, 0x20, 0x30, 0x41. Required: exactly one `sample_valid`, with `sample`=0x28 (0xA1>>2), after the 4th conversion.
- **tx backpressure:** `tx_busy`=1 held for 40 cycles spanning `sample_valid`. Required: no `tx_start` while busy; one `tx_start` with the correct `tx_data` in the cycle after busy drops.
- **Overrun:** `SAMPLE_PERIOD`=20 (below the 36-cycle conversion). Required: `overrun`=1 at the first missed slot; it stays 1 until `enable` goes low.
- **Abort mid-SHIFT:** `enable` dropped during SHIFT. Required: `ad_cs_n`=1 and `ad_sclk`=0 on the next edge; no `sample_valid`; `sample` unchanged.
- **Async reset mid-conversion:** `rstn` pulsed low between clock edges. Required: `ad_cs_n`=1 and all other outputs at their reset values before the next edge.
